sumador_serial_ctrl: RTL and testbench
======================================

// Module: sumador_serial_ctrl
// PURPOSE
//  Sequencer that adds two WIDTH-bit operands over several cycles using one
//  2-bit adder slice with carry-in. Each cycle it processes one 2-bit digit,
//  least significant first. It sits between the switch/register inputs and the
//  result display and is driven by a start/busy/done handshake.
// PARAMETERS
//  WIDTH   8   operand/result width; must be even and >= 2; digits = WIDTH/2
// PORTS
//  clk     in   1      system clock; all state changes on rising edge
//  rst     in   1      synchronous active-high reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  operand A; captured on accepted start
//  b       in   WIDTH  operand B; captured on accepted start
//  busy    out  1      high in RUN and DONE states
//  done    out  1      one-cycle pulse; sum/carry are valid
//  sum     out  WIDTH  registered result; held until next completion
//  carry   out  1      registered carry-out of the MSB digit
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE. busy=0, done=0, sum=0, carry=0.
//   Internal operand, carry and digit counter registers are cleared.
//   rst has priority over every other input, in any state.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//   - start=1: capture a->ra, b->rb; cy=0; cnt=0; next state RUN.
//   - start=0: stay in IDLE. busy=0.
//  RUN (busy=1):
//   - Each cycle: {c,d[1:0]} = ra[1:0] + rb[1:0] + cy, evaluated as 3-bit.
//   - acc <= {d, acc[WIDTH-1:2]}, so digits enter from the MSB side.
//   - ra/rb shift right by 2. cy <= c. cnt <= cnt+1.
//   - When cnt == WIDTH/2-1: load sum <= {d, acc[WIDTH-1:2]} and carry <= c;
//     next state DONE.
//  DONE:
//   - done=1 and busy=1 for exactly one cycle.
//   - Next state IDLE unconditionally.
//  Handshake and latency:
//   - start is ignored in RUN and DONE; it is not queued.
//   - start accepted at edge T -> done=1 in the cycle after edge T+WIDTH/2.
//     For WIDTH=8, done is high 5 cycles after start is sampled.
//   - Back-to-back: with start held high, a new operation is accepted every
//     WIDTH/2+2 cycles.
//  Output stability:
//   - sum and carry change only on the RUN->DONE transition.
//   - They hold the previous result through later IDLE and RUN periods.
//   - a and b may change freely after capture without affecting the result.
//  Arithmetic:
//   - Unsigned. sum = (a+b) mod 2^WIDTH. carry = bit WIDTH of a+b.
//  Reset mid-operation: the operation is aborted; no done pulse; all outputs
//   go to their reset values.
//  WIDTH=2: RUN lasts exactly one cycle.
// TESTING (WIDTH=8 unless noted)
//  1. a=0x35, b=0x4A, start 1 cycle -> done after 5 cycles; sum=0x7F, carry=0;
//     busy high 5 cycles.
//  2. a=0xFF, b=0x01 -> sum=0x00, carry=1 (carry ripples through all 4 digits).
//     a=0xFF, b=0xFF -> sum=0xFE, carry=1.
//  3. Pulse start again 2 cycles into RUN with a=0x00, b=0x00 -> ignored;
//     result of the first operation is unchanged; exactly one done pulse.
//  4. Assert rst during cycle 3 of RUN -> next cycle busy=0, sum=0, carry=0;
//     no done pulse. Then 0x10+0x20 -> sum=0x30.
//  5. Hold start=1 with a stream of random operands for 1000 operations ->
//     done period = 6 cycles; every sum/carry matches the (a+b) model;
//     sum is stable between done pulses.
//  6. WIDTH=2, all 16 (a,b) combinations -> done 2 cycles after start;
//     {carry,sum} == a+b in every case.

Source files
------------

// File: rtl/sumador_serial_ctrl.sv
// ============================================================================
// Module      : sumador_serial_ctrl
// Description : Serial adder sequencer that sums two WIDTH-bit operands one
//               2-bit digit per cycle, LSB first, behind a start/busy/done
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sumador_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int c_DIGITS = WIDTH / 2;
    localparam int c_CNT_W  = (c_DIGITS > 1) ? $clog2(c_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_DIGITS - 1);

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_ra_q, w_ra_d;
    logic [WIDTH-1:0]   r_rb_q, w_rb_d;
    logic [WIDTH-1:0]   r_acc_q, w_acc_d;
    logic [WIDTH-1:0]   r_sum_q, w_sum_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic               r_cy_q, w_cy_d;
    logic               r_carry_q, w_carry_d;
    logic               r_busy_q, w_busy_d;
    logic               r_done_q, w_done_d;

    logic [2:0]         w_digit;
    logic [WIDTH-1:0]   w_acc_shift;

    assign w_digit = {1'b0, r_ra_q[1:0]} + {1'b0, r_rb_q[1:0]} + {2'b00, r_cy_q};

    // New digits enter at the MSB end so the last digit lands in place.
    generate
        if (WIDTH == 2) begin : g_single_digit
            assign w_acc_shift = w_digit[1:0];
        end else begin : g_multi_digit
            assign w_acc_shift = {w_digit[1:0], r_acc_q[WIDTH-1:2]};
        end
    endgenerate

    always_comb begin
        w_state_d = r_state_q;
        w_ra_d    = r_ra_q;
        w_rb_d    = r_rb_q;
        w_acc_d   = r_acc_q;
        w_sum_d   = r_sum_q;
        w_cnt_d   = r_cnt_q;
        w_cy_d    = r_cy_q;
        w_carry_d = r_carry_q;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_ra_d    = a;
                    w_rb_d    = b;
                    w_acc_d   = '0;
                    w_cy_d    = 1'b0;
                    w_cnt_d   = '0;
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_acc_d = w_acc_shift;
                w_ra_d  = r_ra_q >> 2;
                w_rb_d  = r_rb_q >> 2;
                w_cy_d  = w_digit[2];
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_LAST_CNT) begin
                    w_sum_d   = w_acc_shift;
                    w_carry_d = w_digit[2];
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered from the next state.
        w_busy_d = (w_state_d != S_IDLE);
        w_done_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_ra_q    <= '0;
            r_rb_q    <= '0;
            r_acc_q   <= '0;
            r_sum_q   <= '0;
            r_cnt_q   <= '0;
            r_cy_q    <= 1'b0;
            r_carry_q <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ra_q    <= w_ra_d;
            r_rb_q    <= w_rb_d;
            r_acc_q   <= w_acc_d;
            r_sum_q   <= w_sum_d;
            r_cnt_q   <= w_cnt_d;
            r_cy_q    <= w_cy_d;
            r_carry_q <= w_carry_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign busy  = r_busy_q;
    assign done  = r_done_q;
    assign sum   = r_sum_q;
    assign carry = r_carry_q;

endmodule

`default_nettype wire

// File: tb/tb_sumador_serial_ctrl.sv
// ============================================================================
// Module      : tb_sumador_serial_ctrl
// Description : Self-checking bench for sumador_serial_ctrl (WIDTH=8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sumador_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start2;
    logic [7:0] a8, b8, sum8;
    logic [1:0] a2, b2, sum2;
    logic       busy8, done8, carry8;
    logic       busy2, done2, carry2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sumador_serial_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    sumador_serial_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .carry(carry2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int         lat;
        int         busy_n;
        logic [8:0] full;
        full = {1'b0, a} + {1'b0, b};
        @(negedge clk); start8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk); start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat    = 1;
        busy_n = (busy8 === 1'b1) ? 1 : 0;
        while (done8 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            busy_n += (busy8 === 1'b1) ? 1 : 0;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " sum"}, 32'(sum8), 32'(full[7:0]));
        check({tag, " carry"}, 32'(carry8), 32'(full[8]));
        check({tag, " busy cycles"}, 32'(busy_n), 32'd5);
        @(negedge clk);
        check({tag, " done pulse width"}, 32'(done8), 32'd0);
        check({tag, " idle busy"}, 32'(busy8), 32'd0);
    endtask

    task automatic do_op2(input logic [1:0] a, input logic [1:0] b);
        int         lat;
        logic [2:0] full;
        full = {1'b0, a} + {1'b0, b};
        @(negedge clk); start2 = 1'b1; a2 = a; b2 = b;
        @(negedge clk); start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
        lat = 1;
        while (done2 !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("w2 latency", 32'(lat), 32'd2);
        check("w2 carry_sum", 32'({carry2, sum2}), 32'(full));
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] exp_q[$];
        logic [8:0] exp;
        logic [7:0] ra, rb;
        logic [7:0] last_sum;
        logic       last_carry;
        int         dn;
        int         issued;
        int         ndone;
        int         last_c;

        rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        check("reset busy8", 32'(busy8), 32'd0);
        check("reset done8", 32'(done8), 32'd0);
        check("reset sum8", 32'(sum8), 32'd0);
        check("reset carry8", 32'(carry8), 32'd0);
        check("reset w2", 32'({busy2, done2, carry2, sum2}), 32'd0);
        rst = 1'b0;

        do_op8(8'h35, 8'h4A, "basic");
        do_op8(8'hFF, 8'h01, "ripple");
        do_op8(8'hFF, 8'hFF, "max");
        for (int i = 0; i < 4; i++) begin
            do_op8(8'($urandom), 8'($urandom), "rand");
        end

        // Start pulse inside RUN must be ignored and not queued.
        @(negedge clk); start8 = 1'b1; a8 = 8'h5C; b8 = 8'h21;
        dn = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            dn += (done8 === 1'b1) ? 1 : 0;
            if (i == 1) start8 = 1'b0;
            if (i == 3) begin start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; end
            if (i == 4) start8 = 1'b0;
        end
        check("ignore done count", 32'(dn), 32'd1);
        check("ignore sum", 32'(sum8), 32'h7D);
        check("ignore carry", 32'(carry8), 32'd0);
        check("ignore not queued", 32'(busy8), 32'd0);

        // Reset during RUN aborts the operation.
        @(negedge clk); start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        dn = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) start8 = 1'b0;
            if (i == 3) rst = 1'b1;
            if (i == 4) begin
                check("abort busy", 32'(busy8), 32'd0);
                check("abort sum", 32'(sum8), 32'd0);
                check("abort carry", 32'(carry8), 32'd0);
                rst = 1'b0;
            end
            if (i >= 4) dn += (done8 === 1'b1) ? 1 : 0;
        end
        check("abort no done", 32'(dn), 32'd0);
        do_op8(8'h10, 8'h20, "after abort");

        // Streamed operations with start held high.
        last_sum   = 8'h30;
        last_carry = 1'b0;
        issued     = 0;
        ndone      = 0;
        last_c     = 0;
        for (int c = 0; c <= 6010; c++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("stream extra done", 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("stream sum", 32'(sum8), 32'(exp[7:0]));
                    check("stream carry", 32'(carry8), 32'(exp[8]));
                    if (ndone > 0) check("stream period", 32'(c - last_c), 32'd6);
                    last_c     = c;
                    ndone++;
                    last_sum   = exp[7:0];
                    last_carry = exp[8];
                end
            end else begin
                check("stream hold", 32'({carry8, sum8}), 32'({last_carry, last_sum}));
            end
            if (c % 6 == 0) begin
                if (issued < 1000) begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    a8 = ra; b8 = rb; start8 = 1'b1;
                    exp_q.push_back({1'b0, ra} + {1'b0, rb});
                    issued++;
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        check("stream done total", 32'(ndone), 32'd1000);
        check("stream leftover", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 16; i++) begin
            do_op2(2'(i >> 2), 2'(i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
